tl_ul_protocol_monitor: RTL
===========================

// Module: tl_ul_protocol_monitor
// PURPOSE
//  Parametrised, clocked TileLink-UL protocol checker; taps one A/D channel pair passively (no outputs drive the bus).
//  Tracks in-flight requests per source ID, checks handshake stability, legality and response matching, and reports errors.
//  Sits beside each TL-UL port in the subsystem testbench and in the debug build; replaces fixed-width per-port monitors.
// PARAMETERS
//  SOURCE_W   4   width of a_source/d_source; table depth = 2**SOURCE_W
//  ADDR_W     32  address width
//  DATA_W     32  data width; DATA_W/8 = mask width
//  SIZE_W     2   width of a_size/d_size (log2 bytes)
//  MAX_SIZE   2   largest legal size; must be <= log2(DATA_W/8) (single-beat only)
//  ERR_CNT_W  8   width of saturating error counter
//  TIMEOUT    1024 watchdog limit in cycles (used only with TL_MON_TIMEOUT_EN)
// PORTS
//  clock         in   1          sole clock
//  reset_n       in   1          asynchronous, active-low reset
//  a_valid/a_ready in 1          A handshake
//  a_opcode      in   3          0 PutFull, 1 PutPartial, 4 Get
//  a_size        in   SIZE_W     request size
//  a_source      in   SOURCE_W   request source ID
//  a_address     in   ADDR_W     request address
//  a_mask        in   DATA_W/8   byte mask
//  d_valid/d_ready in 1          D handshake
//  d_opcode      in   3          0 AccessAck, 1 AccessAckData
//  d_size        in   SIZE_W     response size
//  d_source      in   SOURCE_W   response source ID
//  err_valid     out  1          one-cycle pulse: >=1 error detected
//  err_code      out  4          lowest-index error of that cycle
//  err_sticky    out  NUM_ERR    OR of all errors since reset
//  err_count     out  ERR_CNT_W  saturating count of error cycles
//  inflight_cnt  out  SOURCE_W+1 number of outstanding requests
// BEHAVIOUR
//  Reset: all outputs 0; source table cleared; watchdog 0; stability trackers idle.
//  a_fire = a_valid&a_ready; d_fire = d_valid&d_ready. All checks combinational on cycle N, reported registered at N+1.
//  Error indices: 0 A_DROP, 1 A_UNSTABLE, 2 A_OPCODE, 3 A_ALIGN, 4 A_DUP_SRC, 5 D_DROP, 6 D_UNSTABLE,
//   7 D_NO_REQ, 8 D_OPCODE, 9 D_SIZE, 10 TIMEOUT. NUM_ERR = 11.
//  Stability: if a_valid&!a_ready at N, at N+1 a_valid=0 -> A_DROP; any payload field changed -> A_UNSTABLE. Same for D.
//  A legality (on a_valid): opcode not in {0,1,4} -> A_OPCODE; a_size>MAX_SIZE, address not size-aligned,
//   Get/PutFull mask != full lane mask for size/address, or PutPartial mask outside that lane mask -> A_ALIGN.
//  Table entry per source: {busy, exp_opcode, size}. a_fire sets busy, exp_opcode=(Get?1:0), size=a_size.
//  a_fire on busy source -> A_DUP_SRC, entry overwritten. d_fire on idle source -> D_NO_REQ, table unchanged.
//  d_fire on busy source: opcode mismatch -> D_OPCODE; d_size!=entry.size -> D_SIZE; entry cleared regardless.
//  Same-cycle a_fire and d_fire: D retires first; a_fire on the source D is retiring is legal (no A_DUP_SRC).
//  inflight_cnt: +1 per a_fire on idle source, -1 per d_fire on busy source; net 0 when both; never wraps.
//  err_count: +1 per error cycle (not per error), saturates at all-ones. err_sticky cleared only by reset.
//  reset_n assertion mid-transaction: table and trackers cleared immediately; post-reset D for old source -> D_NO_REQ.
// CONFIGURATION
//  TL_MON_TIMEOUT_EN defined: watchdog counts cycles with inflight_cnt!=0 and no d_fire; cleared on d_fire or
//   inflight_cnt==0; reaching TIMEOUT raises TIMEOUT once and holds until cleared. Undefined: no counter, bit 10 constant 0.
// STRUCTURE
//  Package tl_mon_pkg: TL-UL opcode localparams, tl_mon_err_e error-index enum, NUM_ERR, lane-mask function.
//  Sub-module tl_mon_source_table: busy/exp_opcode/size storage, set/clear ports, D-before-A ordering, inflight count.
// TESTING
//  Get src 3 size 2 addr 0x100 mask 0xF; AccessAckData src 3 size 2 two cycles later -> no error, inflight 1->0.
//  a_valid high, a_ready low, address 0x100->0x104 next cycle -> err_valid, err_code 1, err_sticky[1]=1.
//  PutFull src 2 accepted twice without D -> err_code 4, inflight_cnt stays 1; AccessAck src 5 unrequested -> err_code 7.
//  Get src 1 answered with AccessAck (opcode 0) size 1 -> err_code 8 (lowest), sticky bits 8 and 9, err_count +1.
//  Same cycle: d_fire src 4 retiring + a_fire src 4 Get -> no error, inflight_cnt unchanged, entry busy.
//  TL_MON_TIMEOUT_EN, TIMEOUT=16: Get src 0, no D for 16 cycles -> err_code 10 once; 256 error cycles -> err_count 255.

Source files
------------

// File: rtl/tl_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tl_mon_pkg
// Description : Shared definitions for the TL-UL protocol monitor.
//               - TL-UL A/D opcode encodings
//               - Error-index enumeration and error count
//               - Byte-lane enable helper for lane-mask checks
// Revision    : 1.0  initial release
// ============================================================================
package tl_mon_pkg;

  // A-channel request opcodes
  localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET         = 3'd4;

  // D-channel response opcodes
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  localparam int NUM_ERR = 11;

  // Error indices. A lower index wins when several errors share a cycle.
  typedef enum logic [3:0] {
    ERR_A_DROP     = 4'd0,
    ERR_A_UNSTABLE = 4'd1,
    ERR_A_OPCODE   = 4'd2,
    ERR_A_ALIGN    = 4'd3,
    ERR_A_DUP_SRC  = 4'd4,
    ERR_D_DROP     = 4'd5,
    ERR_D_UNSTABLE = 4'd6,
    ERR_D_NO_REQ   = 4'd7,
    ERR_D_OPCODE   = 4'd8,
    ERR_D_SIZE     = 4'd9,
    ERR_TIMEOUT    = 4'd10
  } tl_mon_err_e;

  // True when byte lane 'lane' is covered by an access of 2**size_log2
  // bytes starting at byte offset addr_lo within the data word. Called
  // once per lane, so the caller builds a mask of any width.
  function automatic logic tl_lane_en(input int size_log2, input int addr_lo,
                                      input int lane);
    int bytes;
    bytes = 1 << size_log2;
    return (lane >= addr_lo) && (lane < addr_lo + bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_mon_source_table.sv
`default_nettype none
// ============================================================================
// Module      : tl_mon_source_table
// Description : Per-source in-flight request table for the TL-UL monitor.
//               Each entry holds {busy, expected D opcode, size}. A clear
//               (D retire) is applied before a set (A accept), so an A
//               request may reuse the source that D retires in the same
//               cycle. Keeps a non-wrapping count of busy entries.
// Ports       : clock, reset_n     clock, async active-low reset
//               set_*_i            A accept: source, A opcode, size
//               clr_i, clr_src_i   D accept: source
//               set_busy_o         set source busy after this cycle's retire
//               clr_busy_o/op/size entry looked up by the D source
//               inflight_o         number of busy entries
// Revision    : 1.0  initial release
// ============================================================================
module tl_mon_source_table
  import tl_mon_pkg::*;
#(
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                set_i,
  input  logic [SOURCE_W-1:0] set_src_i,
  input  logic [2:0]          set_op_i,
  input  logic [SIZE_W-1:0]   set_size_i,
  input  logic                clr_i,
  input  logic [SOURCE_W-1:0] clr_src_i,
  output logic                set_busy_o,
  output logic                clr_busy_o,
  output logic [2:0]          clr_op_o,
  output logic [SIZE_W-1:0]   clr_size_o,
  output logic [SOURCE_W:0]   inflight_o
);

  localparam int DEPTH = 2 ** SOURCE_W;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [2:0]        op_q   [DEPTH];
  logic [2:0]        op_d   [DEPTH];
  logic [SIZE_W-1:0] size_q [DEPTH];
  logic [SIZE_W-1:0] size_d [DEPTH];
  logic [SOURCE_W:0] cnt_q, cnt_d;

  logic w_retire;
  logic w_alloc;

  assign clr_busy_o = busy_q[clr_src_i];
  assign clr_op_o   = op_q[clr_src_i];
  assign clr_size_o = size_q[clr_src_i];

  // Only a D hitting a busy entry retires it; a stray D leaves the table alone.
  assign w_retire   = clr_i && clr_busy_o;
  // The A source counts as free if D retires it in this same cycle.
  assign set_busy_o = busy_q[set_src_i] && !(w_retire && (clr_src_i == set_src_i));
  assign w_alloc    = set_i && !set_busy_o;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    size_d = size_q;
    cnt_d  = cnt_q;
    if (w_retire) begin
      busy_d[clr_src_i] = 1'b0;
    end
    if (set_i) begin
      busy_d[set_src_i] = 1'b1;
      op_d[set_src_i]   = (set_op_i == TL_A_GET) ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
      size_d[set_src_i] = set_size_i;
    end
    if (w_alloc && !w_retire && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (w_retire && !w_alloc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        size_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      size_q <= size_d;
      cnt_q  <= cnt_d;
    end
  end

  assign inflight_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/tl_ul_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_protocol_monitor
// Description : Passive TileLink-UL protocol checker for one A/D channel
//               pair. Checks handshake stability, A request legality and
//               D response matching against a per-source table. Errors
//               found in cycle N are reported registered in cycle N+1.
//               Requires DATA_W >= 16 and MAX_SIZE <= log2(DATA_W/8).
// Config      : TL_MON_TIMEOUT_EN - when defined, a watchdog flags
//               TIMEOUT after TIMEOUT cycles with requests outstanding
//               and no D accept. When undefined, error bit 10 is 0.
// Ports       : clock, reset_n          clock, async active-low reset
//               a_* / d_*               tapped TL-UL A and D channels
//               err_valid, err_code     pulse + lowest error index
//               err_sticky, err_count   accumulated errors since reset
//               inflight_cnt            outstanding request count
// Revision    : 1.0  initial release
// ============================================================================
module tl_ul_protocol_monitor
  import tl_mon_pkg::*;
#(
  parameter int SOURCE_W  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SIZE_W    = 2,
  parameter int MAX_SIZE  = 2,
  parameter int ERR_CNT_W = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_valid,
  input  logic                 a_ready,
  input  logic [2:0]           a_opcode,
  input  logic [SIZE_W-1:0]    a_size,
  input  logic [SOURCE_W-1:0]  a_source,
  input  logic [ADDR_W-1:0]    a_address,
  input  logic [DATA_W/8-1:0]  a_mask,
  input  logic                 d_valid,
  input  logic                 d_ready,
  input  logic [2:0]           d_opcode,
  input  logic [SIZE_W-1:0]    d_size,
  input  logic [SOURCE_W-1:0]  d_source,
  output logic                 err_valid,
  output logic [3:0]           err_code,
  output logic [NUM_ERR-1:0]   err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [SOURCE_W:0]    inflight_cnt
);

  localparam int MASK_W = DATA_W / 8;
  localparam int LANE_W = $clog2(MASK_W);

  logic w_a_fire, w_d_fire;
  assign w_a_fire = a_valid & a_ready;
  assign w_d_fire = d_valid & d_ready;

  // ---------------------------------------------------------------- trackers
  // A stalled beat (valid without ready) is captured so the next cycle can
  // confirm it is still presented unchanged.
  logic                a_pend_q;
  logic [2:0]          a_op_q;
  logic [SIZE_W-1:0]   a_size_q;
  logic [SOURCE_W-1:0] a_src_q;
  logic [ADDR_W-1:0]   a_addr_q;
  logic [MASK_W-1:0]   a_mask_q;
  logic                d_pend_q;
  logic [2:0]          d_op_q;
  logic [SIZE_W-1:0]   d_size_q;
  logic [SOURCE_W-1:0] d_src_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_pend_q <= 1'b0;
      a_op_q   <= '0;
      a_size_q <= '0;
      a_src_q  <= '0;
      a_addr_q <= '0;
      a_mask_q <= '0;
      d_pend_q <= 1'b0;
      d_op_q   <= '0;
      d_size_q <= '0;
      d_src_q  <= '0;
    end else begin
      a_pend_q <= a_valid & ~a_ready;
      a_op_q   <= a_opcode;
      a_size_q <= a_size;
      a_src_q  <= a_source;
      a_addr_q <= a_address;
      a_mask_q <= a_mask;
      d_pend_q <= d_valid & ~d_ready;
      d_op_q   <= d_opcode;
      d_size_q <= d_size;
      d_src_q  <= d_source;
    end
  end

  // ------------------------------------------------------------ source table
  logic                w_set_busy;
  logic                w_clr_busy;
  logic [2:0]          w_clr_op;
  logic [SIZE_W-1:0]   w_clr_size;
  logic [SOURCE_W:0]   w_inflight;

  tl_mon_source_table #(
    .SOURCE_W (SOURCE_W),
    .SIZE_W   (SIZE_W)
  ) u_table (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_i      (w_a_fire),
    .set_src_i  (a_source),
    .set_op_i   (a_opcode),
    .set_size_i (a_size),
    .clr_i      (w_d_fire),
    .clr_src_i  (d_source),
    .set_busy_o (w_set_busy),
    .clr_busy_o (w_clr_busy),
    .clr_op_o   (w_clr_op),
    .clr_size_o (w_clr_size),
    .inflight_o (w_inflight)
  );

  // --------------------------------------------------------------- watchdog
  logic w_tmo_hit;

`ifdef TL_MON_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] wd_q, wd_d;

  // The counter parks at TIMEOUT so the error fires once per stall.
  always_comb begin
    wd_d      = wd_q;
    w_tmo_hit = 1'b0;
    if (w_d_fire || (w_inflight == '0)) begin
      wd_d = '0;
    end else if (wd_q != TMO_W'(TIMEOUT)) begin
      wd_d      = wd_q + TMO_W'(1);
      w_tmo_hit = (wd_d == TMO_W'(TIMEOUT));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // No watchdog; a negative TIMEOUT is meaningless, so this is always 0.
  assign w_tmo_hit = (TIMEOUT < 0);
`endif

  // ---------------------------------------------------------- error checks
  logic [MASK_W-1:0] w_lane;
  logic [LANE_W-1:0] w_align;
  logic              w_op_legal;
  logic [NUM_ERR-1:0] w_err;

  always_comb begin
    for (int i = 0; i < MASK_W; i++) begin
      w_lane[i] = tl_lane_en(int'(a_size), int'(a_address[LANE_W-1:0]), i);
    end
    // Address offset bits that must be zero for a naturally aligned access.
    for (int i = 0; i < LANE_W; i++) begin
      w_align[i] = (i < int'(a_size));
    end
  end

  assign w_op_legal = (a_opcode == TL_A_PUT_FULL) || (a_opcode == TL_A_PUT_PARTIAL) ||
                      (a_opcode == TL_A_GET);

  always_comb begin
    w_err = '0;

    if (a_pend_q) begin
      if (!a_valid) begin
        w_err[ERR_A_DROP] = 1'b1;
      end else if ({a_opcode, a_size, a_source, a_address, a_mask} !=
                   {a_op_q, a_size_q, a_src_q, a_addr_q, a_mask_q}) begin
        w_err[ERR_A_UNSTABLE] = 1'b1;
      end
    end

    if (d_pend_q) begin
      if (!d_valid) begin
        w_err[ERR_D_DROP] = 1'b1;
      end else if ({d_opcode, d_size, d_source} != {d_op_q, d_size_q, d_src_q}) begin
        w_err[ERR_D_UNSTABLE] = 1'b1;
      end
    end

    if (a_valid) begin
      if (!w_op_legal) begin
        w_err[ERR_A_OPCODE] = 1'b1;
      end
      if ((int'(a_size) > MAX_SIZE) || ((a_address[LANE_W-1:0] & w_align) != '0)) begin
        w_err[ERR_A_ALIGN] = 1'b1;
      end
      if (((a_opcode == TL_A_GET) || (a_opcode == TL_A_PUT_FULL)) && (a_mask != w_lane)) begin
        w_err[ERR_A_ALIGN] = 1'b1;
      end
      if ((a_opcode == TL_A_PUT_PARTIAL) && ((a_mask & ~w_lane) != '0)) begin
        w_err[ERR_A_ALIGN] = 1'b1;
      end
    end

    if (w_a_fire && w_set_busy) begin
      w_err[ERR_A_DUP_SRC] = 1'b1;
    end

    if (w_d_fire) begin
      if (!w_clr_busy) begin
        w_err[ERR_D_NO_REQ] = 1'b1;
      end else begin
        if (d_opcode != w_clr_op) begin
          w_err[ERR_D_OPCODE] = 1'b1;
        end
        if (d_size != w_clr_size) begin
          w_err[ERR_D_SIZE] = 1'b1;
        end
      end
    end

    w_err[ERR_TIMEOUT] = w_tmo_hit;
  end

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  logic [3:0] w_code;
  always_comb begin
    w_code = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (w_err[i]) begin
        w_code = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------- report
  logic                 err_valid_q;
  logic [3:0]           err_code_q;
  logic [NUM_ERR-1:0]   err_sticky_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_sticky_q <= '0;
      err_count_q  <= '0;
    end else begin
      err_valid_q  <= |w_err;
      err_code_q   <= w_code;
      err_sticky_q <= err_sticky_q | w_err;
      if ((|w_err) && !(&err_count_q)) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_count_q;
  assign inflight_cnt = w_inflight;

endmodule
`default_nettype wire
